// File: rtl/define.vh
// Shared UART constants: register address, default frame length and
// scheduler state encodings.
`ifndef UART_DEFINE_VH
`define UART_DEFINE_VH

`define UART_ADDR        32'h1000_0000
`define UART_BYTE_CYCLES 4340
`define SCHED_IDLE       1'b0
`define SCHED_BUSY       1'b1

`endif

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmit scheduler. It can accept one byte, or a
// two-byte pair (din2 first, then din), on a single edge.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     push2,
  input  logic                     pop,
  input  logic [7:0]               din,
  input  logic [7:0]               din2,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [1:0]    n_in;
  logic          do_pop;
  logic [LW-1:0] level_nxt;

  always_comb begin
    do_pop    = pop && !empty;
    n_in      = push2 ? 2'd2 : (push ? 2'd1 : 2'd0);
    level_nxt = level + LW'(n_in) - LW'(do_pop);
  end

  assign dout = mem[rptr];

  always_ff @(posedge clk) begin
    if (push2) begin
      mem[wptr]           <= din2;
      mem[wptr + PW'(1)]  <= din;
    end else if (push) begin
      mem[wptr] <= din;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wptr  <= wptr + PW'(n_in);
      rptr  <= rptr + PW'(do_pop);
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// Paces CPU stores to the UART: queues bytes and strobes uart_wr once per
// frame time. Optional LF->CRLF expansion under UART_TX_SCHED_CRLF_EN.
`include "define.vh"

module uart_tx_sched #(
  parameter int DEPTH       = 16,
  parameter int BYTE_CYCLES = `UART_BYTE_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   clr_ovf,
  output logic                   uart_wr,
  output logic [7:0]             uart_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(BYTE_CYCLES);
  // Reload so the next launch lands exactly BYTE_CYCLES edges after this one.
  localparam logic [CW-1:0] CNT_RELOAD = CW'(BYTE_CYCLES - 1);

  typedef enum logic {
    IDLE = `SCHED_IDLE,
    BUSY = `SCHED_BUSY
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          wr_nxt;
  logic [7:0]    dat_nxt;
  logic          pop;
  logic          push;
  logic          push2;
  logic          drop;
  logic [7:0]    fifo_dout;

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .push2 (push2),
    .pop   (pop),
    .din   (wr_data),
    .din2  (8'h0D),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

`ifdef UART_TX_SCHED_CRLF_EN
  logic          is_lf;
  logic [LW:0]   free;

  // A pop on the same edge frees a slot for the CR/LF pair.
  always_comb begin
    is_lf = (wr_data == 8'h0A);
    free  = (LW+1)'(DEPTH) - {1'b0, level} + {{LW{1'b0}}, pop};
    push  = wr_en && !is_lf && !full;
    push2 = wr_en && is_lf && (free >= (LW+1)'(2));
    drop  = wr_en && !push && !push2;
  end
`else
  always_comb begin
    push  = wr_en && !full;
    push2 = 1'b0;
    drop  = wr_en && full;
  end
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_nxt    = 1'b0;
    dat_nxt   = uart_dat;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          dat_nxt   = fifo_dout;
          wr_nxt    = 1'b1;
          cnt_nxt   = CNT_RELOAD;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else if (!empty) begin
          pop     = 1'b1;
          dat_nxt = fifo_dout;
          wr_nxt  = 1'b1;
          cnt_nxt = CNT_RELOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      uart_wr  <= 1'b0;
      uart_dat <= 8'h00;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      uart_wr  <= wr_nxt;
      uart_dat <= dat_nxt;
      // A dropped push wins over a simultaneous clear.
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched (DEPTH=4, BYTE_CYCLES=8): directed steps followed by
// random traffic, checked against a queue-based model of the scheduler.
module tb_uart_tx_sched;
  localparam int DEPTH       = 4;
  localparam int BYTE_CYCLES = 8;
  localparam int LW          = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          clr_ovf;
  logic          uart_wr;
  logic [7:0]    uart_dat;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;

  uart_tx_sched #(.DEPTH(DEPTH), .BYTE_CYCLES(BYTE_CYCLES)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr_ovf  (clr_ovf),
    .uart_wr  (uart_wr),
    .uart_dat (uart_dat),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Model: bytes waiting, time of last launch, and expected registered outputs.
  logic [7:0] exp_q[$];
  int         cyc;
  int         last_launch;
  logic       exp_wr;
  logic [7:0] exp_dat;
  logic       exp_ovf;
  int         n_vec;
  int         n_err;
  int         lvl_max;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("uart_wr",  32'(uart_wr),  32'(exp_wr));
    chk("uart_dat", 32'(uart_dat), 32'(exp_dat));
    chk("level",    32'(level),    32'(exp_q.size()));
    chk("full",     32'(full),     32'(exp_q.size() == DEPTH));
    chk("empty",    32'(empty),    32'(exp_q.size() == 0));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  // Called at a negedge; drives inputs, advances one edge, checks at next negedge.
  task automatic step(input logic w, input logic [7:0] d, input logic c);
    bit launch, accept, drop, pair;
    wr_en   = w;
    wr_data = d;
    clr_ovf = c;
    @(posedge clk);
    launch = (exp_q.size() > 0) && (cyc - last_launch >= BYTE_CYCLES);
    pair   = 1'b0;
`ifdef UART_TX_SCHED_CRLF_EN
    pair = (d == 8'h0A);
`endif
    if (pair)
      accept = w && ((DEPTH - exp_q.size() + (launch ? 1 : 0)) >= 2);
    else
      accept = w && (exp_q.size() < DEPTH);
    drop = w && !accept;
    if (launch) begin
      exp_dat     = exp_q.pop_front();
      last_launch = cyc;
    end
    exp_wr = launch;
    if (accept) begin
      if (pair) exp_q.push_back(8'h0D);
      exp_q.push_back(d);
    end
    if (drop) exp_ovf = 1'b1;
    else if (c) exp_ovf = 1'b0;
    cyc++;
    @(negedge clk);
    if (int'(level) > lvl_max) lvl_max = int'(level);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  // Asserts reset part-way through a cycle and checks that it acts at once.
  task automatic mid_reset();
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    exp_wr      = 1'b0;
    exp_dat     = 8'h00;
    exp_ovf     = 1'b0;
    last_launch = cyc - 1000;
    check_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    cyc         = 0;
    last_launch = -1000;
    exp_wr      = 1'b0;
    exp_dat     = 8'h00;
    exp_ovf     = 1'b0;
    rst         = 1'b1;
    wr_en       = 1'b0;
    wr_data     = 8'h00;
    clr_ovf     = 1'b0;
    #1;
    check_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single byte: strobe two edges after the push, then nothing more.
    step(1'b1, 8'h41, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("single_wr",  32'(uart_wr),  32'd1);
    chk("single_dat", 32'(uart_dat), 32'h41);
    idle(20);

    // Backlog of three bytes, one frame apart.
    lvl_max = 0;
    step(1'b1, 8'h31, 1'b0);
    step(1'b1, 8'h32, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    idle(25);
    chk("backlog_peak", 32'(lvl_max), 32'd2);

    // Fill past capacity: sixth push dropped, then clear overflow.
    for (int i = 0; i < 6; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    idle(45);
    step(1'b0, 8'h00, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);
    idle(2);

    // Reset while busy with a backlog.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
    chk("pre_rst_level", 32'(level), 32'd3);
    mid_reset();
    idle(20);

    // Push on the very edge the scheduler relaunches with one byte queued.
    step(1'b1, 8'h51, 1'b0);
    step(1'b1, 8'h52, 1'b0);
    idle(7);
    step(1'b1, 8'h53, 1'b0);
    chk("simul_level", 32'(level), 32'd1);
    idle(30);

`ifdef UART_TX_SCHED_CRLF_EN
    step(1'b1, 8'h0A, 1'b0);
    idle(20);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h61 + 8'(i), 1'b0);
    step(1'b1, 8'h0A, 1'b0);
    chk("crlf_ovf",   32'(overflow), 32'd1);
    chk("crlf_level", 32'(level),    32'd3);
    idle(40);
    step(1'b0, 8'h00, 1'b1);
`endif

    // Random traffic with bursty and sparse phases.
    for (int i = 0; i < 600; i++) begin
      logic       w, c;
      logic [7:0] d;
      w = ($urandom_range(0, 99) < ((i % 200) < 100 ? 60 : 15));
      d = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
      c = ($urandom_range(0, 19) == 0);
      step(w, d, c);
      if (i == 300) mid_reset();
    end
    idle(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
